// File: rtl/sd_resp_pkg.sv
// Shared definitions for the sector responder: FSM state encoding,
// default sector geometry and the host command direction codes.
package sd_resp_pkg;

    // Default sector geometry; ADDR_W must equal log2(BLK_BYTES).
    localparam int unsigned BLK_BYTES_DEF = 512;
    localparam int unsigned ADDR_W_DEF    = $clog2(BLK_BYTES_DEF);

    // host_cmd_wr encoding.
    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_RD_XFER = 3'd2,
        S_WR_ADDR = 3'd3,
        S_WR_WAIT = 3'd4,
        S_WR_SEND = 3'd5,
        S_DONE    = 3'd6
    } sd_state_e;

endpackage

// File: rtl/sd_stall_timer.sv
// Host stall watchdog for the sector responder (used only when SD_TIMEOUT_EN
// is defined).
//   clk_sys, reset : clock and asynchronous active-high reset
//   clear          : restart the stall count (handshake or idle)
//   count_en       : a cycle spent waiting on the host
//   expire_c       : combinational, high on the stall cycle that reaches
//                    TIMEOUT_CYCLES
module sd_stall_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating stall count; clear has priority.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the stall cycle that would make the count reach the limit.
    assign expire_c = count_en && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sd_sector_responder.sv
// Sector responder: turns core-side sd_rd/sd_wr sector requests into host
// commands and moves one BLK_BYTES sector between the host byte stream and
// the core buffer.
//   clk_sys, reset          : clock, asynchronous active-high reset
//   sd_lba/sd_rd/sd_wr      : core request (LBA latched at accept)
//   sd_ack                  : high for the whole transfer
//   sd_buff_addr/dout/wr    : core buffer write port (read direction)
//   sd_buff_din             : core buffer read data, 1 cycle after addr
//   host_cmd_*              : command to the host bridge (valid/ready)
//   host_rx_*               : host-to-core bytes (valid/ready)
//   host_tx_*               : core-to-host bytes (valid/ready)
//   xfer_err                : one-cycle pulse on a host stall abort
// Optional feature: define SD_TIMEOUT_EN to abort a transfer after the host
// stalls for TIMEOUT_CYCLES cycles.
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int unsigned BLK_BYTES      = BLK_BYTES_DEF,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [ADDR_W-1:0] sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic              host_cmd_valid,
    output logic              host_cmd_wr,
    output logic [31:0]       host_cmd_lba,
    input  logic              host_cmd_ready,
    input  logic [7:0]        host_rx_data,
    input  logic              host_rx_valid,
    output logic              host_rx_ready,
    output logic [7:0]        host_tx_data,
    output logic              host_tx_valid,
    input  logic              host_tx_ready,
    output logic              xfer_err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_BYTES - 1);

    sd_state_e         state_q, state_d;
    logic [31:0]       lba_q, lba_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              buff_wr_q, buff_wr_d;
    logic              ack_q, ack_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              rx_ready_q, rx_ready_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;

    logic cmd_hs_c;
    logic rx_hs_c;
    logic tx_hs_c;

    assign cmd_hs_c = cmd_valid_q & host_cmd_ready;
    assign rx_hs_c  = rx_ready_q & host_rx_valid;
    assign tx_hs_c  = tx_valid_q & host_tx_ready;

`ifdef SD_TIMEOUT_EN
    logic err_q, err_d;
    logic stall_hit_c;
    logic stall_en_c;
    logic stall_clr_c;

    // Only host-facing waits count; the error cycle itself is not a stall.
    assign stall_en_c  = ((state_q == S_CMD) || (state_q == S_RD_XFER) ||
                          (state_q == S_WR_SEND)) && !err_q;
    assign stall_clr_c = cmd_hs_c | rx_hs_c | tx_hs_c | (state_q == S_IDLE);

    sd_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (stall_clr_c),
        .count_en(stall_en_c),
        .expire_c(stall_hit_c)
    );
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        lba_d       = lba_q;
        dir_d       = dir_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        buff_wr_d   = 1'b0;
        ack_d       = ack_q;
        cmd_valid_d = cmd_valid_q;
        rx_ready_d  = rx_ready_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
`ifdef SD_TIMEOUT_EN
        err_d       = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d       = sd_lba;
                    dir_d       = sd_rd ? CMD_RD : CMD_WR;
                    idx_d       = '0;
                    addr_d      = '0;
                    ack_d       = 1'b1;
                    cmd_valid_d = 1'b1;
                    state_d     = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_hs_c) begin
                    cmd_valid_d = 1'b0;
                    if (dir_q == CMD_RD) begin
                        rx_ready_d = 1'b1;
                        state_d    = S_RD_XFER;
                    end else begin
                        state_d    = S_WR_ADDR;
                    end
                end
            end
            S_RD_XFER: begin
                if (rx_hs_c) begin
                    dout_d    = host_rx_data;
                    buff_wr_d = 1'b1;
                    addr_d    = idx_q;
                    idx_d     = idx_q + ADDR_W'(1);
                    // Stop consuming once the whole sector has been taken.
                    if (idx_q == LAST_IDX) begin
                        rx_ready_d = 1'b0;
                    end
                end
                // Leave only after the final strobe is visible to the core.
                if (buff_wr_q && (addr_q == LAST_IDX)) begin
                    ack_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_WR_ADDR: begin
                addr_d  = idx_q;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                tx_data_d  = sd_buff_din;
                tx_valid_d = 1'b1;
                state_d    = S_WR_SEND;
            end
            S_WR_SEND: begin
                if (tx_hs_c) begin
                    tx_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        ack_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        // Address is presented on WR_ADDR entry so the buffer
                        // data is ready by the end of WR_WAIT.
                        idx_d   = idx_q + ADDR_W'(1);
                        addr_d  = idx_q + ADDR_W'(1);
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_DONE: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SD_TIMEOUT_EN
        // Stall abort: pulse the error and drop the host side, then finish.
        if (stall_hit_c) begin
            err_d       = 1'b1;
            cmd_valid_d = 1'b0;
            rx_ready_d  = 1'b0;
            tx_valid_d  = 1'b0;
        end
        if (err_q) begin
            ack_d   = 1'b0;
            state_d = S_DONE;
        end
`endif
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lba_q       <= '0;
            dir_q       <= 1'b0;
            idx_q       <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            buff_wr_q   <= 1'b0;
            ack_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            rx_ready_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
`ifdef SD_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lba_q       <= lba_d;
            dir_q       <= dir_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            buff_wr_q   <= buff_wr_d;
            ack_q       <= ack_d;
            cmd_valid_q <= cmd_valid_d;
            rx_ready_q  <= rx_ready_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
`ifdef SD_TIMEOUT_EN
            err_q       <= err_d;
`endif
        end
    end

    assign sd_ack         = ack_q;
    assign sd_buff_addr   = addr_q;
    assign sd_buff_dout   = dout_q;
    assign sd_buff_wr     = buff_wr_q;
    assign host_cmd_valid = cmd_valid_q;
    assign host_cmd_wr    = dir_q;
    assign host_cmd_lba   = lba_q;
    assign host_rx_ready  = rx_ready_q;
    assign host_tx_data   = tx_data_q;
    assign host_tx_valid  = tx_valid_q;
`ifdef SD_TIMEOUT_EN
    assign xfer_err       = err_q;
`else
    assign xfer_err       = 1'b0;
`endif

endmodule
